// File: rtl/hazard_pkg.sv
// Shared definitions for the D-stage hazard scoreboard: forward-select
// encoding, stage indices, the in-flight producer record and its ageing rule.
package hazard_pkg;

  localparam int DEF_REG_AW = 5;
  localparam int DEF_TNEW_W = 2;

  // Forward select 0 means "use the register file value".
  localparam int FWD_RF = 0;

  // Stage indices inside the scoreboard (0 is the stage right after D).
  localparam int STG_E = 0;
  localparam int STG_M = 1;
  localparam int STG_W = 2;

  // One in-flight producer: does it write a register, which one, and how
  // many cycles remain until its result exists.
  typedef struct packed {
    logic                  valid;
    logic [DEF_REG_AW-1:0] dst;
    logic [DEF_TNEW_W-1:0] tnew;
  } stage_rec_t;

  // A producer moves one stage closer to its result each cycle; never below 0.
  function automatic logic [DEF_TNEW_W-1:0] tnew_age(input logic [DEF_TNEW_W-1:0] t);
    return (t == '0) ? t : t - DEF_TNEW_W'(1);
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// HI/LO busy tracker: reloads with the mult/div latency when a mult/div
// enters E, then counts down to zero; busy while the count is non-zero.
module md_busy_counter #(
  parameter int MD_LAT = 5,
  parameter int CNT_W  = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic busy
);

  logic [CNT_W-1:0] count_reg;

  // Load on an accepted mult/div, otherwise decay towards zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= CNT_W'(MD_LAT);
    end else if (count_reg != '0) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign busy = (count_reg != '0);

endmodule

// File: rtl/tnew_scoreboard.sv
// Tnew/Tuse hazard scoreboard beside the D stage. Keeps an aged record of
// every in-flight producer after D, raises stall when a D source is needed
// before its producer has the value, selects the forwarding stage, and
// stalls HI/LO users while a mult/div is busy.
// Optional build macro TNEW_SCOREBOARD_STATS_EN enables the 32-bit
// saturating stall_count; without it stall_count is constant zero.
module tnew_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int REG_AW     = DEF_REG_AW,
  parameter int TNEW_W     = DEF_TNEW_W,
  parameter int MD_LAT     = 5,
  parameter int MD_CNT_W   = 3,
  parameter int FWD_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [TNEW_W-1:0] d_tuse_rs,
  input  logic [TNEW_W-1:0] d_tuse_rt,
  input  logic [REG_AW-1:0] d_dst,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic              d_md_start,
  input  logic              d_md_use,
  output logic              stall,
  output logic [FWD_W-1:0]  fwd_sel_rs,
  output logic [FWD_W-1:0]  fwd_sel_rt,
  output logic              md_busy,
  output logic [31:0]       stall_count
);

  // Records are sized by the package defaults; REG_AW/TNEW_W must match them.
  stage_rec_t stage_reg [NUM_STAGES];

  logic [NUM_STAGES-1:0] hit_rs;
  logic [NUM_STAGES-1:0] hit_rt;

  logic              rs_hit;
  logic [FWD_W-1:0]  rs_sel;
  logic [TNEW_W-1:0] rs_tnew;
  logic              rt_hit;
  logic [FWD_W-1:0]  rt_sel;
  logic [TNEW_W-1:0] rt_tnew;

  logic data_stall;
  logic md_stall;
  logic md_load;

  // Per-stage match: a live record writing a non-zero register equal to the source.
  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_match
      assign hit_rs[gi] = stage_reg[gi].valid && (stage_reg[gi].dst != '0) &&
                          (stage_reg[gi].dst == d_rs);
      assign hit_rt[gi] = stage_reg[gi].valid && (stage_reg[gi].dst != '0) &&
                          (stage_reg[gi].dst == d_rt);
    end
  endgenerate

  // Youngest match wins: scan oldest to youngest so the lowest index lands last.
  always_comb begin
    rs_hit  = 1'b0;
    rs_sel  = FWD_W'(FWD_RF);
    rs_tnew = '0;
    rt_hit  = 1'b0;
    rt_sel  = FWD_W'(FWD_RF);
    rt_tnew = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (hit_rs[k]) begin
        rs_hit  = 1'b1;
        rs_sel  = FWD_W'(k + 1);
        rs_tnew = stage_reg[k].tnew;
      end
      if (hit_rt[k]) begin
        rt_hit  = 1'b1;
        rt_sel  = FWD_W'(k + 1);
        rt_tnew = stage_reg[k].tnew;
      end
    end
  end

  assign data_stall = d_valid && ((rs_hit && (rs_tnew > d_tuse_rs)) ||
                                  (rt_hit && (rt_tnew > d_tuse_rt)));
  assign md_stall   = d_valid && d_md_use && md_busy;
  assign stall      = data_stall || md_stall;

  // Forward only once the youngest producer's value exists.
  assign fwd_sel_rs = (d_valid && rs_hit && (rs_tnew == '0)) ? rs_sel : FWD_W'(FWD_RF);
  assign fwd_sel_rt = (d_valid && rt_hit && (rt_tnew == '0)) ? rt_sel : FWD_W'(FWD_RF);

  // Shift the pipe: D enters E (bubble on stall), older records age and move on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        stage_reg[i] <= '0;
      end
    end else begin
      stage_reg[STG_E] <= {d_valid & ~stall, d_dst, d_tnew};
      for (int i = 1; i < NUM_STAGES; i++) begin
        stage_reg[i] <= {stage_reg[i-1].valid, stage_reg[i-1].dst,
                         tnew_age(stage_reg[i-1].tnew)};
      end
    end
  end

  assign md_load = d_valid && d_md_start && !stall;

  md_busy_counter #(
    .MD_LAT (MD_LAT),
    .CNT_W  (MD_CNT_W)
  ) u_md_busy (
    .clk   (clk),
    .reset (reset),
    .load  (md_load),
    .busy  (md_busy)
  );

`ifdef TNEW_SCOREBOARD_STATS_EN
  logic [31:0] stall_count_reg;

  // Count stalled cycles, holding at the maximum instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_reg <= '0;
    end else if (stall && (stall_count_reg != 32'hFFFF_FFFF)) begin
      stall_count_reg <= stall_count_reg + 32'd1;
    end
  end

  assign stall_count = stall_count_reg;
`else
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_tnew_scoreboard.sv
// Self-checking bench for tnew_scoreboard. The reference model keeps a list
// of accepted producers stamped with the edge they entered E; a producer's
// stage is its age in edges and its remaining tnew is max(0, tnew - age).
module tb_tnew_scoreboard;

  localparam int NS  = 3;
  localparam int AW  = 5;
  localparam int TW  = 2;
  localparam int LAT = 5;
  localparam int FW  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          d_valid;
  logic [AW-1:0] d_rs, d_rt, d_dst;
  logic [TW-1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic          d_md_start, d_md_use;
  logic          stall;
  logic [FW-1:0] fwd_sel_rs, fwd_sel_rt;
  logic          md_busy;
  logic [31:0]   stall_count;

  int total = 0;
  int bad   = 0;

  tnew_scoreboard dut (
    .clk        (clk),
    .reset      (reset),
    .d_valid    (d_valid),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_dst      (d_dst),
    .d_tnew     (d_tnew),
    .d_md_start (d_md_start),
    .d_md_use   (d_md_use),
    .stall      (stall),
    .fwd_sel_rs (fwd_sel_rs),
    .fwd_sel_rt (fwd_sel_rt),
    .md_busy    (md_busy),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int dst;
    int tnew0;
    int t_acc;
  } prod_t;

  prod_t prods[$];
  int    n_edges = 0;
  int    md_acc  = 0;
  bit    md_seen = 1'b0;
  int    stall_cycles = 0;

  function automatic int exp_count();
`ifdef TNEW_SCOREBOARD_STATS_EN
    return stall_cycles;
`else
    return 0;
`endif
  endfunction

  // Youngest in-flight producer of register r decides stall and forwarding.
  function automatic void lookup(input int r, input int tuse, output bit stl, output int fwd);
    int best_k = -1;
    int rem    = 0;
    stl = 1'b0;
    fwd = 0;
    if (r != 0) begin
      foreach (prods[i]) begin
        int age;
        age = n_edges - prods[i].t_acc;
        if (prods[i].dst == r && age < NS && (best_k < 0 || age < best_k)) begin
          best_k = age;
          rem    = (prods[i].tnew0 > age) ? prods[i].tnew0 - age : 0;
        end
      end
      if (best_k >= 0) begin
        stl = (rem > tuse);
        fwd = (rem == 0) ? best_k + 1 : 0;
      end
    end
  endfunction

  function automatic void model_reset();
    prods.delete();
    md_seen      = 1'b0;
    stall_cycles = 0;
  endfunction

  task automatic idle_inputs();
    d_valid = 0; d_rs = 0; d_rt = 0; d_tuse_rs = 0; d_tuse_rt = 0;
    d_dst = 0; d_tnew = 0; d_md_start = 0; d_md_use = 0;
  endtask

  // One D-stage cycle: drive, check all outputs against the model, clock, update model.
  task automatic cycle(input string tag, input bit v, input int rs, input int rt,
                       input int tu_rs, input int tu_rt, input int dst, input int tn,
                       input bit ms, input bit mu,
                       output bit o_stall, output int o_frs, output int o_frt);
    bit s_rs, s_rt, busy, e_stall;
    int f_rs, f_rt;
    d_valid = v; d_rs = AW'(rs); d_rt = AW'(rt); d_tuse_rs = TW'(tu_rs); d_tuse_rt = TW'(tu_rt);
    d_dst = AW'(dst); d_tnew = TW'(tn); d_md_start = ms; d_md_use = mu;
    @(negedge clk);
    lookup(rs, tu_rs, s_rs, f_rs);
    lookup(rt, tu_rt, s_rt, f_rt);
    busy    = md_seen && ((n_edges - md_acc) < LAT);
    e_stall = v && (s_rs || s_rt || (mu && busy));
    if (!v) begin
      f_rs = 0;
      f_rt = 0;
    end
    total++;
    if (stall !== e_stall) begin
      bad++;
      $display("FAIL %s stall: got %0b want %0b", tag, stall, e_stall);
    end
    total++;
    if (fwd_sel_rs !== FW'(f_rs)) begin
      bad++;
      $display("FAIL %s fwd_sel_rs: got %0d want %0d", tag, fwd_sel_rs, f_rs);
    end
    total++;
    if (fwd_sel_rt !== FW'(f_rt)) begin
      bad++;
      $display("FAIL %s fwd_sel_rt: got %0d want %0d", tag, fwd_sel_rt, f_rt);
    end
    total++;
    if (md_busy !== busy) begin
      bad++;
      $display("FAIL %s md_busy: got %0b want %0b", tag, md_busy, busy);
    end
    total++;
    if (stall_count !== 32'(exp_count())) begin
      bad++;
      $display("FAIL %s stall_count: got %0d want %0d", tag, stall_count, exp_count());
    end
    $display("[%s] v=%0b rs=%0d rt=%0d dst=%0d tnew=%0d -> stall=%0b frs=%0d frt=%0d busy=%0b",
             tag, v, rs, rt, dst, tn, stall, fwd_sel_rs, fwd_sel_rt, md_busy);
    o_stall = stall;
    o_frs   = int'(fwd_sel_rs);
    o_frt   = int'(fwd_sel_rt);
    @(posedge clk);
    n_edges++;
    if (v && !e_stall && dst != 0) prods.push_back('{dst, tn, n_edges});
    if (v && !e_stall && ms) begin
      md_acc  = n_edges;
      md_seen = 1'b1;
    end
    if (e_stall) stall_cycles++;
    while (prods.size() > 0 && (n_edges - prods[0].t_acc) >= NS) void'(prods.pop_front());
    #1;
  endtask

  task automatic nops(input int cnt);
    bit s; int a, b;
    for (int i = 0; i < cnt; i++) cycle("nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, s, a, b);
  endtask

  // Synchronous-looking release of the async reset, with the pipe idle.
  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    n_edges++;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bit s; int a, b;
    idle_inputs();
    reset = 1'b0;
    #12;
    total++;
    if ({stall, fwd_sel_rs, fwd_sel_rt, md_busy} !== '0 || stall_count !== 32'd0) begin
      bad++;
      $display("FAIL reset_state: got stall=%0b frs=%0d frt=%0d busy=%0b cnt=%0d want all 0",
               stall, fwd_sel_rs, fwd_sel_rt, md_busy, stall_count);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    n_edges++;
    #1;
    // Three live producers, then a D reader that must stall on the oldest.
    cycle("p1", 1, 0, 0, 3, 3, 1, 3, 0, 0, s, a, b);
    cycle("p2", 1, 0, 0, 3, 3, 2, 3, 0, 0, s, a, b);
    cycle("p3", 1, 0, 0, 3, 3, 3, 3, 0, 0, s, a, b);
    d_valid = 1; d_rs = 1; d_tuse_rs = 0; d_rt = 0; d_dst = 4; d_tnew = 1;
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_stall: got %0b want 1", stall);
    end
    reset = 1'b0;
    #1;
    total++;
    if ({stall, fwd_sel_rs, fwd_sel_rt, md_busy} !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got stall=%0b frs=%0d frt=%0d busy=%0b want 0",
               stall, fwd_sel_rs, fwd_sel_rt, md_busy);
    end
    model_reset();
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    n_edges++;
    #1;
    cycle("add_after_rst", 1, 1, 1, 1, 1, 2, 1, 0, 0, s, a, b);
    total++;
    if (s !== 1'b0 || a !== 0) begin
      bad++;
      $display("FAIL add_after_reset: got stall=%0b frs=%0d want 0 0", s, a);
    end
    nops(4);
  endtask

  task automatic test_lw_use();
    bit s; int a, b;
    cycle("lw8", 1, 29, 0, 1, 3, 8, 2, 0, 0, s, a, b);
    cycle("addu_stall", 1, 8, 0, 1, 3, 9, 1, 0, 0, s, a, b);
    total++;
    if (s !== 1'b1) begin bad++; $display("FAIL lw_use_stall: got %0b want 1", s); end
    cycle("addu_go", 1, 8, 0, 1, 3, 9, 1, 0, 0, s, a, b);
    total++;
    if (s !== 1'b0 || a !== 0) begin
      bad++;
      $display("FAIL lw_use_release: got stall=%0b frs=%0d want 0 0", s, a);
    end
    cycle("rd8_w", 1, 8, 0, 1, 3, 0, 0, 0, 0, s, a, b);
    total++;
    if (s !== 1'b0 || a !== 3) begin
      bad++;
      $display("FAIL lw_use_fwd_w: got stall=%0b frs=%0d want 0 3", s, a);
    end
    nops(4);
  endtask

  task automatic test_store_fwd();
    bit s; int a, b;
    cycle("ori5", 1, 0, 0, 1, 3, 5, 1, 0, 0, s, a, b);
    cycle("sw5", 1, 29, 5, 1, 2, 0, 0, 0, 0, s, a, b);
    total++;
    if (s !== 1'b0 || b !== 0) begin
      bad++;
      $display("FAIL store_no_stall: got stall=%0b frt=%0d want 0 0", s, b);
    end
    cycle("rd5_m", 1, 0, 5, 3, 2, 0, 0, 0, 0, s, a, b);
    total++;
    if (b !== 2) begin bad++; $display("FAIL store_fwd_m: got frt=%0d want 2", b); end
    nops(4);
  endtask

  task automatic test_shadow();
    bit s; int a, b;
    int stalls = 0;
    cycle("addu3", 1, 0, 0, 3, 3, 3, 1, 0, 0, s, a, b);
    cycle("lw3", 1, 29, 0, 1, 3, 3, 2, 0, 0, s, a, b);
    for (int i = 0; i < 6; i++) begin
      cycle("beq3", 1, 3, 0, 0, 0, 0, 0, 0, 0, s, a, b);
      if (!s) break;
      stalls++;
      total++;
      if (a !== 0) begin bad++; $display("FAIL shadow_fwd_during_stall: got %0d want 0", a); end
    end
    total++;
    if (stalls !== 2 || a !== 3) begin
      bad++;
      $display("FAIL shadow_youngest: got stalls=%0d frs=%0d want 2 3", stalls, a);
    end
    nops(4);
  endtask

  task automatic test_md_busy();
    bit s; int a, b;
    int stalls = 0;
    cycle("mult", 1, 0, 0, 0, 0, 0, 0, 1, 1, s, a, b);
    for (int i = 0; i < 10; i++) begin
      cycle("mfhi", 1, 0, 0, 3, 3, 7, 1, 0, 1, s, a, b);
      if (!s) break;
      stalls++;
    end
    total++;
    if (stalls !== LAT || md_busy !== 1'b0) begin
      bad++;
      $display("FAIL md_stall_len: got stalls=%0d busy=%0b want %0d 0", stalls, md_busy, LAT);
    end
    nops(4);
  endtask

  task automatic test_stats();
    bit s; int a, b;
    int want;
    apply_reset();
    for (int r = 0; r < 4; r++) begin
      cycle("lw8", 1, 29, 0, 1, 3, 8, 2, 0, 0, s, a, b);
      cycle("use8", 1, 8, 0, 1, 3, 9, 1, 0, 0, s, a, b);
      cycle("use8", 1, 8, 0, 1, 3, 9, 1, 0, 0, s, a, b);
      nops(3);
    end
`ifdef TNEW_SCOREBOARD_STATS_EN
    want = 4;
`else
    want = 0;
`endif
    total++;
    if (stall_count !== 32'(want)) begin
      bad++;
      $display("FAIL stats_count: got %0d want %0d", stall_count, want);
    end
  endtask

  task automatic test_random();
    bit s; int a, b;
    for (int i = 0; i < 300; i++) begin
      bit v, ms, mu;
      v  = ($urandom_range(0, 9) < 8);
      ms = ($urandom_range(0, 19) == 0);
      mu = ms || ($urandom_range(0, 9) == 0);
      cycle("rnd", v, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3), ms, mu, s, a, b);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_lw_use();
    test_store_fwd();
    test_shadow();
    test_md_busy();
    test_random();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
